// File: rtl/sevseg_display_ndigit.sv
// sevseg_display_ndigit
//   Multiplexed N-digit seven-segment driver. A binary value is accepted
//   through a load handshake, converted to BCD by a sequential
//   shift-add-3 engine (one bit per cycle), and scanned out over a shared
//   active-low segment bus with leading-zero blanking, per-digit decimal
//   points, blinking and overflow dashes.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   value     unsigned binary value to display
//   load      convert and display `value` (ignored while busy)
//   busy      conversion in progress
//   ovf       last completed conversion exceeded 10^DIGITS-1
//   blank_lz  enable leading-zero blanking
//   blink     enable display blinking
//   dp_in     per-digit decimal point, active high
//   seg       segments {g,f,e,d,c,b,a}, active low
//   dp        decimal point, active low
//   an        digit enables, active low (bit 0 = rightmost digit)
module sevseg_display_ndigit #(
  parameter int DIGITS  = 4,
  parameter int VAL_W   = 14,
  parameter int DIV_W   = 18,
  parameter int BLINK_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VAL_W-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              ovf,
  input  logic              blank_lz,
  input  logic              blink,
  input  logic [DIGITS-1:0] dp_in,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = DIGITS * 4;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(VAL_W + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Smallest value that no longer fits in DIGITS decimal digits.
  localparam longint unsigned OVF_LIMIT = pow10(DIGITS);

  // Double-dabble correction: any nibble >= 5 would carry past 9 after
  // the next left shift, so pre-add 3 to make it carry into the next digit.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  logic [VAL_W-1:0]     shift_val;
  logic [BCD_W-1:0]     bcd_work;
  logic [CNT_W-1:0]     iter_cnt;
  logic                 ovf_pend;
  logic [BCD_W-1:0]     disp;
  logic [DIV_W-1:0]     prescaler;
  logic [IDX_W-1:0]     idx;
  logic [BLINK_W-1:0]   blink_cnt;

  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_next;
  logic [3:0]           cur_nib;
  logic                 blank_now;
  logic                 blink_off;
  logic [6:0]           seg_dec;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bcd_adj   = add3(bcd_work);
    bcd_next  = {bcd_adj[BCD_W-2:0], shift_val[VAL_W-1]};
    cur_nib   = disp[idx*4 +: 4];
    // Digit idx is a leading zero when it and every digit above it are 0.
    blank_now = blank_lz && !ovf && (idx != '0) &&
                ((disp >> {idx, 2'b00}) == '0);
    blink_off = blink && blink_cnt[BLINK_W-1];
    seg_dec   = 7'b0111111;
    case (cur_nib)
      4'd0: seg_dec = 7'b1000000;
      4'd1: seg_dec = 7'b1111001;
      4'd2: seg_dec = 7'b0100100;
      4'd3: seg_dec = 7'b0110000;
      4'd4: seg_dec = 7'b0011001;
      4'd5: seg_dec = 7'b0010010;
      4'd6: seg_dec = 7'b0000010;
      4'd7: seg_dec = 7'b1111000;
      4'd8: seg_dec = 7'b0000000;
      4'd9: seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the display register is a handful of flops, not a memory, so
      // it is reset together with the rest of the state.
      shift_val <= '0;
      bcd_work  <= '0;
      iter_cnt  <= '0;
      ovf_pend  <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      disp      <= '0;
      prescaler <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      an        <= '1;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      // Conversion engine.
      if (busy) begin
        shift_val <= shift_val << 1;
        bcd_work  <= bcd_next;
        iter_cnt  <= iter_cnt + CNT_W'(1);
        if (iter_cnt == CNT_W'(VAL_W - 1)) begin
          disp <= ovf_pend ? '1 : bcd_next;
          ovf  <= ovf_pend;
          busy <= 1'b0;
        end
      end else if (load) begin
        shift_val <= value;
        bcd_work  <= '0;
        iter_cnt  <= '0;
        ovf_pend  <= (64'(value) >= OVF_LIMIT);
        busy      <= 1'b1;
      end

      // Scan timing.
      prescaler <= prescaler + DIV_W'(1);
      blink_cnt <= blink_cnt + BLINK_W'(1);
      if (&prescaler)
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);

      // Registered output stage.
      an  <= blink_off ? '1 : ~(DIGITS'(1) << idx);
      dp  <= blink_off ? 1'b1 : ~dp_in[idx];
      seg <= blank_now ? 7'h7F : seg_dec;
    end
  end

endmodule

// File: tb/tb_sevseg_display_ndigit.sv
module tb_sevseg_display_ndigit;

  localparam int DIGITS  = 4;
  localparam int VAL_W   = 14;
  localparam int DIV_W   = 2;
  localparam int BLINK_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [VAL_W-1:0]  value = '0;
  logic              load = 1'b0;
  logic              busy;
  logic              ovf;
  logic              blank_lz = 1'b0;
  logic              blink = 1'b0;
  logic [DIGITS-1:0] dp_in = '0;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] an;

  sevseg_display_ndigit #(
    .DIGITS(DIGITS), .VAL_W(VAL_W), .DIV_W(DIV_W), .BLINK_W(BLINK_W)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .busy(busy),
    .ovf(ovf), .blank_lz(blank_lz), .blink(blink), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'h7F;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000, 7'b0000000,
                               7'b0010000};
  int p10 [DIGITS] = '{1, 10, 100, 1000};

  // Reference model: decimal value on display (-1 = dashes), pending
  // conversion countdown, and the number of clocks since reset release.
  int t      = 0;
  bit m_busy = 0;
  int m_left = 0;
  int m_val  = 0;
  int m_disp = 0;
  bit m_ovf  = 0;

  // One clock: update the model at the edge, compare all outputs later.
  task automatic cyc();
    int pd, pt, slot, q;
    bit po, off, blank;
    logic [6:0] e_seg;
    logic [DIGITS-1:0] e_an;
    logic e_dp;
    @(posedge clk);
    pd = m_disp; po = m_ovf; pt = t;
    if (reset) begin
      m_busy = 0; m_disp = 0; m_ovf = 0; t = 0;
      e_an = '1; e_seg = BLANK; e_dp = 1'b1;
    end else begin
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_ovf  = (m_val >= 10 ** DIGITS);
          m_disp = m_ovf ? -1 : m_val;
        end
      end else if (load) begin
        m_busy = 1; m_left = VAL_W; m_val = int'(value);
      end
      // Outputs reflect the scan position and display before this edge.
      slot = (pt >> DIV_W) % DIGITS;
      off  = blink && ((pt % (2 ** BLINK_W)) >= 2 ** (BLINK_W - 1));
      e_an = off ? '1 : ~(DIGITS'(1) << slot);
      e_dp = off ? 1'b1 : ~dp_in[slot];
      if (pd < 0) e_seg = DASH;
      else begin
        q     = pd / p10[slot];
        blank = blank_lz && !po && slot > 0 && q == 0;
        e_seg = blank ? BLANK : seg_tab[q % 10];
      end
      t++;
    end
    @(negedge clk);
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("busy", 32'(busy), 32'(m_busy));
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // Accept a load and measure how long busy stays high (bounded).
  task automatic load_and_wait(input int v);
    int n = 0;
    value = VAL_W'(v); load = 1'b1;
    cyc();
    load = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    for (int i = 0; i < 40 && busy; i++) begin
      cyc();
      n++;
    end
    check("busy_len", 32'(n), VAL_W);
    run(2);
  endtask

  // Scan one full frame and compare each slot against fixed patterns.
  task automatic scan_expect(input string tag, input logic [6:0] s0,
                             input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3);
    logic [DIGITS-1:0] seen = '0;
    for (int i = 0; i < 4 * (2 ** DIV_W); i++) begin
      cyc();
      case (an)
        4'b1110: begin check({tag, "_s0"}, 32'(seg), 32'(s0)); seen[0] = 1'b1; end
        4'b1101: begin check({tag, "_s1"}, 32'(seg), 32'(s1)); seen[1] = 1'b1; end
        4'b1011: begin check({tag, "_s2"}, 32'(seg), 32'(s2)); seen[2] = 1'b1; end
        4'b0111: begin check({tag, "_s3"}, 32'(seg), 32'(s3)); seen[3] = 1'b1; end
        default: check({tag, "_an_onehot"}, 32'(an), 32'hE);
      endcase
    end
    check({tag, "_all_slots"}, 32'(seen), 32'hF);
  endtask

  initial begin
    // Reset and idle scan of zeros.
    reset = 1'b1;
    run(3);
    check("rst_an", 32'(an), 32'hF);
    reset = 1'b0;
    scan_expect("zero", seg_tab[0], seg_tab[0], seg_tab[0], seg_tab[0]);

    load_and_wait(1234);
    scan_expect("v1234", seg_tab[4], seg_tab[3], seg_tab[2], seg_tab[1]);

    load_and_wait(9999);
    check("ovf_9999", 32'(ovf), 32'd0);
    scan_expect("v9999", seg_tab[9], seg_tab[9], seg_tab[9], seg_tab[9]);

    load_and_wait(10000);
    check("ovf_10000", 32'(ovf), 32'd1);
    scan_expect("v10000", DASH, DASH, DASH, DASH);

    blank_lz = 1'b1;
    load_and_wait(7);
    scan_expect("lz7", seg_tab[7], BLANK, BLANK, BLANK);
    load_and_wait(0);
    scan_expect("lz0", seg_tab[0], BLANK, BLANK, BLANK);
    blank_lz = 1'b0;

    // Second load during busy is dropped.
    value = VAL_W'(42); load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    value = VAL_W'(99); load = 1'b1;
    cyc();
    load = 1'b0;
    run(VAL_W);
    dp_in = 4'b0100;
    scan_expect("v42", seg_tab[2], seg_tab[4], seg_tab[0], seg_tab[0]);
    dp_in = '0;

    // Reset in the middle of a conversion discards it.
    value = VAL_W'(1234); load = 1'b1;
    cyc();
    load = 1'b0;
    run(5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    run(30);
    scan_expect("abort", seg_tab[0], seg_tab[0], seg_tab[0], seg_tab[0]);

    // Blink over two full blink periods.
    load_and_wait(5678);
    blink = 1'b1;
    run(2 * (2 ** BLINK_W) + 3);
    blink = 1'b0;

    // Randomized traffic against the model.
    for (int k = 0; k < 120; k++) begin
      blank_lz = 1'($urandom_range(0, 1));
      blink    = ($urandom_range(0, 7) == 0);
      dp_in    = DIGITS'($urandom);
      case ($urandom_range(0, 3))
        0: value = VAL_W'($urandom_range(0, 99));
        1: value = VAL_W'($urandom_range(9990, 10010));
        default: value = VAL_W'($urandom);
      endcase
      load = 1'b1;
      cyc();
      load = 1'b0;
      for (int i = 0, n = $urandom_range(4, 40); i < n; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          value = VAL_W'($urandom);
          load  = 1'b1;
        end
        reset = ($urandom_range(0, 299) == 0);
        cyc();
        load  = 1'b0;
        reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevseg_display_ndigit.md
Name: sevseg_display_ndigit

Overview:
- Parametrised N-digit multiplexed seven-segment driver.
- Takes an unsigned binary value through a load handshake and converts it to BCD with a multi-cycle shift-add-3 engine, so there are no combinational divide or modulo chains.
- Scans the digits over a shared active-low segment bus, with leading-zero blanking, per-digit decimal points, blink mode and overflow dashes.
- Sits between the game score/timer logic and the board display pins.

Parameters:
- DIGITS, 4: number of digits driven. Range 1..8. Index 0 is the rightmost digit.
- VAL_W, 14: width of the binary input value.
- DIV_W, 18: width of the scan prescaler. The active digit advances every 2^DIV_W clocks.
- BLINK_W, 26: width of the blink counter. Its MSB is the blink phase.

Ports:
- clk, input, 1: system clock (100 MHz).
- reset, input, 1: synchronous, active-high reset.
- value, input, VAL_W: unsigned binary value to display.
- load, input, 1: request to convert and display `value`.
- busy, output, 1: conversion in progress. `load` is ignored while busy is high.
- ovf, output, 1: the last accepted value was greater than 10^DIGITS-1.
- blank_lz, input, 1: enable leading-zero blanking.
- blink, input, 1: enable display blinking.
- dp_in, input, DIGITS: per-digit decimal point, active high.
- seg, output, 7: {g,f,e,d,c,b,a}, active low.
- dp, output, 1: decimal point, active low.
- an, output, DIGITS: digit enables, active low.

Behaviour:
- Reset state (seg, an and dp take these values on the first clk edge with reset high):
  - an = all 1; seg = 7'h7F; dp = 1.
  - busy = 0; ovf = 0.
  - Display BCD register = all digits 0.
  - Scan index = 0; prescaler = 0; blink counter = 0.
  - Any conversion in flight is aborted and its result discarded.
- Load acceptance:
  - A load is accepted on a clk edge where load=1 and busy=0 and reset=0.
  - At acceptance: capture `value`, clear the shift register, set busy=1.
- Conversion (double-dabble):
  - Exactly VAL_W iterations, one per cycle.
  - Each iteration: add 3 to every BCD nibble that is >= 5, then shift left 1 bit, bringing in the next MSB of the captured value.
  - The BCD working register is DIGITS*4 bits; higher bits are discarded.
  - On the final iteration the result is written to the display register and busy falls on the same edge.
  - Busy is high for exactly VAL_W cycles. The new digits can reach seg on the edge after busy falls.
- Overflow:
  - At acceptance, compare the captured value >= 10^DIGITS (compile-time constant).
  - If true, the result written at completion is all 4'hF nibbles (dash code) and ovf=1.
  - Otherwise ovf=0.
  - ovf updates on the same edge busy falls and holds until the next completed conversion.
- A second load while busy is ignored; it is neither queued nor latched.
- Scan:
  - The prescaler increments every cycle.
  - On wrap from all-1 to 0, the scan index increments, wrapping from DIGITS-1 to 0. This also holds when DIGITS is not a power of 2.
- Output stage (registered, one cycle after the index and display register):
  - an: bit `idx` = 0, all others 1.
  - seg: decode of display nibble[idx]:
    - 0..9 use the standard active-low patterns, e.g. 0 = 1000000, 4 = 0011001, 7 = 1111000.
    - Any other code gives dash 0111111.
  - dp = ~dp_in[idx].
- Leading-zero blanking:
  - Applies when blank_lz=1 and ovf=0.
  - Digit i>0 is blanked (seg = 7'h7F) if nibbles i..DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - an still cycles normally; dp is unaffected by blanking.
- Blink:
  - The blink counter runs freely.
  - When blink=1 and the counter MSB=1: an = all 1 and dp = 1.
  - Blink does not affect conversion or scanning.
- Simultaneous events:
  - reset dominates load.
  - A load arriving on the same edge busy falls is ignored; it is accepted on the next edge if still asserted.

Test Plan (bench uses DIV_W=2, BLINK_W=6):
- Reset held 3 cycles -> an=4'b1111, seg=7'h7F, busy=0, ovf=0. After release: an=1110 with seg=1000000, then the sequence 1101, 1011, 0111 each showing 0, each digit lasting 4 cycles.
- load value=1234 for 1 cycle -> busy=1 for exactly 14 cycles. Then the an=1110 slot shows 4 (0011001), 1101 shows 3 (0110000), 1011 shows 2 (0100100), 0111 shows 1 (1111001).
- load 9999 -> ovf=0 and all digits show 9 (0010000). Then load 10000 -> ovf=1 and every slot shows seg=0111111.
- blank_lz=1, load 7 -> slot 1110 shows 1111000; slots 1101, 1011 and 0111 show seg=7'h7F. Then load 0 -> slot 0 shows 1000000 and the rest are blank.
- load 42, then load 99 two cycles later -> 99 ignored, busy falls 14 cycles after the first accept, display shows 0042. dp_in=4'b0100 -> dp=0 only in slot an=1011.
- load 1234, then assert reset at busy cycle 5 -> busy=0, display all 0, no 1234 ever appears. Separately, blink=1 -> an=all 1 whenever blink counter MSB=1, with normal scan otherwise.
